// File: rtl/retire_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  retire_trace_buffer_if
//  Retire-side and monitor-side handshake bundle for retire_trace_buffer.
//  Revision: 1.0 - initial release
// ============================================================================
interface retire_trace_buffer_if;
   logic        ret_valid;
   logic [31:0] ret_pc;
   logic [31:0] ret_instr;
   logic        ret_rd_we;
   logic [4:0]  ret_rd_addr;
   logic [31:0] ret_rd_data;

   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_seq;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_rd_we;
   logic [4:0]  out_rd_addr;
   logic [31:0] out_rd_data;

   modport master (
      output ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data,
      output out_ready,
      input  out_valid, out_seq, out_pc, out_instr, out_rd_we, out_rd_addr, out_rd_data
   );

   modport slave (
      input  ret_valid, ret_pc, ret_instr, ret_rd_we, ret_rd_addr, ret_rd_data,
      input  out_ready,
      output out_valid, out_seq, out_pc, out_instr, out_rd_we, out_rd_addr, out_rd_data
   );
endinterface
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  retire_trace_buffer
//  Sequence-stamped retire-trace FIFO with drop accounting; optional core
//  back-pressure enabled by defining TRACE_STALL_EN.
//  Revision: 1.0 - initial release
// ============================================================================
module retire_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   retire_trace_buffer_if.slave       bus,
   output logic [$clog2(DEPTH):0]     level,
   output logic [DROP_W-1:0]          drop_count,
   output logic                       stall
);
   localparam int c_AW = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } rec_t;

   rec_t              r_mem [DEPTH];
   logic [c_AW:0]     r_wptr;
   logic [c_AW:0]     r_rptr;
   logic [c_AW:0]     r_level;
   logic [31:0]       r_seq;
   logic [DROP_W-1:0] r_drop;

   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [c_AW:0]     w_level_nxt;
   logic [c_AW-1:0]   w_head_idx;
   rec_t              w_rec;
   rec_t              w_head;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign w_pop   = !w_empty && bus.out_ready;
   assign w_push  = bus.ret_valid && (!w_full || w_pop);
   assign w_drop  = bus.ret_valid && w_full && !w_pop;

   // Writeback fields are cleaned so x0 and non-writing instructions compare exactly.
   always_comb begin
      w_rec       = '0;
      w_rec.seq   = r_seq;
      w_rec.pc    = bus.ret_pc;
      w_rec.instr = bus.ret_instr;
      w_rec.we    = bus.ret_rd_we;
      if (bus.ret_rd_we) begin
         w_rec.addr = bus.ret_rd_addr;
         if (bus.ret_rd_addr != 5'd0) begin
            w_rec.data = bus.ret_rd_data;
         end
      end
   end

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + (c_AW+1)'(1);
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - (c_AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_seq   <= '0;
         r_drop  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_rec;
            r_wptr <= r_wptr + (c_AW+1)'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + (c_AW+1)'(1);
         end
         if (bus.ret_valid) begin
            r_seq <= r_seq + 32'd1;
         end
         if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_W'(1);
         end
         r_level <= w_level_nxt;
      end
   end

   // When empty the slot behind the read pointer still holds the last popped record.
   assign w_head_idx = w_empty ? (r_rptr[c_AW-1:0] - c_AW'(1)) : r_rptr[c_AW-1:0];
   assign w_head     = r_mem[w_head_idx];

   assign bus.out_valid   = !w_empty;
   assign bus.out_seq     = w_head.seq;
   assign bus.out_pc      = w_head.pc;
   assign bus.out_instr   = w_head.instr;
   assign bus.out_rd_we   = w_head.we;
   assign bus.out_rd_addr = w_head.addr;
   assign bus.out_rd_data = w_head.data;
   assign level           = r_level;
   assign drop_count      = r_drop;

`ifdef TRACE_STALL_EN
   logic r_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall <= 1'b0;
      end else begin
         r_stall <= (w_level_nxt >= (c_AW+1)'(DEPTH-1));
      end
   end

   assign stall = r_stall;
`else
   assign stall = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  tb_retire_trace_buffer
//  Directed plus random stimulus checked against a queue-based trace model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_retire_trace_buffer;
   localparam int c_DEPTH  = 16;
   localparam int c_DROP_W = 3;

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } trec_t;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [$clog2(c_DEPTH):0]  level;
   logic [c_DROP_W-1:0]       drop_count;
   logic                      stall;

   retire_trace_buffer_if bus ();

   retire_trace_buffer #(.DEPTH(c_DEPTH), .DROP_W(c_DROP_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .level      (level),
      .drop_count (drop_count),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   trec_t       q[$];
   trec_t       m_last;
   logic [31:0] m_seq;
   int          m_drop;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      trec_t h;
      logic  exp_stall;
      h = (q.size() > 0) ? q[0] : m_last;
`ifdef TRACE_STALL_EN
      exp_stall = (q.size() >= c_DEPTH - 1);
`else
      exp_stall = 1'b0;
`endif
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("out_seq", 64'(bus.out_seq), 64'(h.seq));
      chk("out_pc", 64'(bus.out_pc), 64'(h.pc));
      chk("out_instr", 64'(bus.out_instr), 64'(h.instr));
      chk("out_rd_we_addr", 64'({bus.out_rd_we, bus.out_rd_addr}), 64'({h.we, h.addr}));
      chk("out_rd_data", 64'(bus.out_rd_data), 64'(h.data));
      chk("level", 64'(level), 64'(q.size()));
      chk("drop_count", 64'(drop_count), 64'(m_drop));
      chk("stall", 64'(stall), 64'(exp_stall));
   endtask

   // One clock: drive inputs, advance the model by the retire/drain rules, compare.
   task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic rdy, input logic rst);
      bit    pop;
      bit    full;
      trec_t r;
      bus.ret_valid   = v;
      bus.ret_pc      = pc;
      bus.ret_instr   = instr;
      bus.ret_rd_we   = we;
      bus.ret_rd_addr = addr;
      bus.ret_rd_data = data;
      bus.out_ready   = rdy;
      reset           = rst;
      if (rst) begin
         q.delete();
         m_seq  = 32'd0;
         m_drop = 0;
         m_last = '0;
      end else begin
         pop  = (q.size() > 0) && rdy;
         full = (q.size() == c_DEPTH);
         if (pop) m_last = q.pop_front();
         if (v) begin
            if (!full || pop) begin
               r.seq   = m_seq;
               r.pc    = pc;
               r.instr = instr;
               r.we    = we;
               r.addr  = we ? addr : 5'd0;
               r.data  = (we && addr != 5'd0) ? data : 32'd0;
               q.push_back(r);
            end else if (m_drop < (1 << c_DROP_W) - 1) begin
               m_drop++;
            end
            m_seq = m_seq + 32'd1;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] pc, input logic rdy);
      step(1'b1, pc, $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom, rdy, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom, rdy, 1'b0);
   endtask

   initial begin
      m_seq  = 32'd0;
      m_drop = 0;
      m_last = '0;
      @(negedge clk);
      step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);

      // In-order stream with a ready monitor.
      for (int i = 0; i < 4; i++) push(32'h100 + 32'(4 * i), 1'b1);
      idle(1'b1);

      // x0 writeback and a non-writing store.
      step(1'b1, 32'h200, 32'h0550_0013, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
      step(1'b1, 32'h204, 32'h00A1_2023, 1'b0, 5'd7, 32'hDEAD, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // Overflow with a stalled monitor, then drain and resume.
      step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) push(32'h1000 + 32'(4 * i), 1'b0);
      for (int i = 0; i < 17; i++) idle(1'b1);
      push(32'h2000, 1'b0);

      // Full FIFO with simultaneous push and pop, then drop saturation.
      for (int i = 0; i < 16; i++) push(32'h3000 + 32'(4 * i), 1'b0);
      push(32'h4000, 1'b1);
      for (int i = 0; i < 6; i++) push(32'h5000 + 32'(4 * i), 1'b0);
      for (int i = 0; i < 18; i++) idle(1'b1);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
              1'($urandom_range(0, 2) != 0), 1'b0);
      end

      // Sequence counter wrap.
      step(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      force dut.r_seq = 32'hFFFF_FFFE;
      #1;
      release dut.r_seq;
      m_seq = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) push(32'h6000 + 32'(4 * i), 1'b1);
      idle(1'b1);

      // Reset with records queued, push ignored during reset.
      for (int i = 0; i < 5; i++) push(32'h7000 + 32'(4 * i), 1'b0);
      step(1'b1, 32'h7100, 32'h1, 1'b1, 5'd3, 32'h9, 1'b1, 1'b1);
      push(32'h8000, 1'b0);
      idle(1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
